obi_apb_bridge_mc: RTL and testbench
====================================

Name: obi_apb_bridge_mc

Overview:
Parametrised OBI-subordinate to APB4-master bridge with multi-subordinate address decode, full APB setup/access phasing, registered responses and a per-transfer timeout. It sits between the core-side OBI peripheral crossbar and a cluster of up to NumApb APB peripherals. It replaces fixed 32-bit, single-PSEL bridging with configurable widths and channels. Decode failures and hung subordinates are reported as OBI errors instead of stalling the bus.

Parameters:
AddrWidth, 32, OBI/APB address width
DataWidth, 32, data width; must be a multiple of 8
NumApb, 4, number of APB subordinates (PSEL lines), 1..16
SelLsb, 12, LSB of the subordinate-index field; index = addr[SelLsb +: max(1,$clog2(NumApb))]
TimeoutCycles, 255, maximum ACCESS cycles before forced error; 0 disables the timeout
Pprot, 3'b010, constant driven on PPROT

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
obi_req_i  in  1  OBI request
obi_gnt_o  out  1  OBI grant
obi_addr_i  in  AddrWidth  request address
obi_we_i  in  1  write enable
obi_be_i  in  DataWidth/8  byte enables
obi_wdata_i  in  DataWidth  write data
obi_rvalid_o  out  1  response valid, one-cycle pulse
obi_rdata_o  out  DataWidth  read data
obi_err_o  out  1  response error
apb_paddr_o  out  AddrWidth  APB address (full OBI address)
apb_psel_o  out  NumApb  one-hot select
apb_penable_o  out  1  access phase
apb_pwrite_o  out  1  write
apb_pwdata_o  out  DataWidth  write data
apb_pstrb_o  out  DataWidth/8  write strobes
apb_pprot_o  out  3  protection, equals Pprot
apb_prdata_i  in  NumApb*DataWidth  read data, packed per subordinate
apb_pready_i  in  NumApb  ready, per subordinate
apb_pslverr_i  in  NumApb  error, per subordinate

Behaviour:
- Single clock clk_i. Reset rst_i is synchronous and active-high.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- obi_gnt_o = obi_req_i && (state==IDLE || state==RESP) && !rst_i. It is combinational.
- On grant, the bridge latches addr, we, be, wdata and the decoded index into registers.
  - Index < NumApb: go to SETUP.
  - Otherwise (decode error): go to RESP with err=1 and rdata=0. No APB activity occurs.
- SETUP: psel[idx]=1, penable=0. Always lasts 1 cycle, then ACCESS.
- ACCESS: psel[idx]=1, penable=1.
  - pready[idx]=1: capture rdata and err, go to RESP.
    - rdata = prdata[idx] for reads, 0 for writes.
    - err = pslverr[idx].
  - Timeout: a counter clears on SETUP entry and increments every ACCESS cycle without pready. If TimeoutCycles>0 and the counter reaches TimeoutCycles, go to RESP with err=1 and rdata=0.
  - pready arriving on the same cycle as the timeout wins, so it is a normal completion.
- RESP: obi_rvalid_o=1 for exactly 1 cycle; psel=0 and penable=0. Next state is SETUP or RESP if a new request is granted, else IDLE.
- Latency:
  - Zero-wait-state access: 3 cycles from grant to rvalid.
  - Decode error: 1 cycle from grant to rvalid.
  - Back-to-back throughput: 1 transfer per 3 cycles.
- APB outputs come from registers; only psel and penable depend on state. paddr, pwrite and pwdata are held stable from SETUP through ACCESS.
- apb_pstrb_o = latched be for writes, all zeros for reads, per APB4.
- Inputs from unselected subordinates are ignored. pready is ignored outside ACCESS.
- Reset values: state IDLE; all APB outputs 0 except pprot=Pprot; obi_rvalid_o=0, obi_rdata_o=0, obi_err_o=0; gnt=0; counter=0.
- Reset mid-transfer: on the next cycle psel and penable are 0 and no rvalid is issued. The aborted transfer is lost, and the master is expected to be reset alongside.
- obi_rdata_o and obi_err_o hold their last values outside rvalid.

Decomposition:
- Package obi_apb_bridge_pkg holds:
  - the state_e enum (IDLE, SETUP, ACCESS, RESP);
  - the default PPROT constant;
  - a function that computes the index width from NumApb.
- Sub-module obi_apb_timeout_cnt: clear/enable inputs, expired output; parametrised by TimeoutCycles, with width $clog2(TimeoutCycles+1).

Test Plan:
1. Read 0x0000_2004, sub 2 gives pready on the first ACCESS cycle with prdata=0xDEAD_BEEF -> psel=4'b0100 with penable=0, then penable=1 next cycle; rvalid 3 cycles after grant with rdata=0xDEAD_BEEF, err=0.
2. Write 0x0000_3010, be=4'b0011, wdata=0x1234_5678; sub 3 holds pready low for 2 cycles, then pready=1 with pslverr=1 -> pstrb=4'b0011, pwrite=1, pwdata stable across all ACCESS cycles; rvalid with err=1, rdata=0.
3. NumApb=3, read 0x0000_3000 -> psel stays 0; rvalid 1 cycle after grant with err=1, rdata=0.
4. TimeoutCycles=8, read sub 1 whose pready is stuck at 0 -> exactly 8 ACCESS cycles, then psel=0; rvalid with err=1, rdata=0. Repeat with pready arriving on cycle 8 -> err=0.
5. req held high for two reads to subs 0 and 1 -> second gnt on the same cycle as the first rvalid; psel sequence 0001, 0001, 0000, 0010, 0010; responses returned in order.
6. Assert rst_i for 1 cycle during ACCESS -> next cycle psel=0, penable=0, rvalid=0, gnt=0; bridge accepts a new request afterwards.

Source files
------------

// File: rtl/obi_apb_bridge_pkg.sv
// ============================================================================
// Module : obi_apb_bridge_pkg
// Brief  : Shared FSM encoding, PPROT default and index-width helper for the
//          OBI-to-APB bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package obi_apb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam logic [2:0] c_PPROT_DEFAULT = 3'b010;

   // A single subordinate still needs a one-bit index field.
   function automatic int idx_width(input int num_apb);
      return (num_apb <= 1) ? 1 : $clog2(num_apb);
   endfunction

endpackage

`default_nettype wire

// File: rtl/obi_apb_timeout_cnt.sv
// ============================================================================
// Module : obi_apb_timeout_cnt
// Brief  : ACCESS-phase cycle counter; flags the cycle on which the count
//          reaches TimeoutCycles (never when TimeoutCycles is 0).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module obi_apb_timeout_cnt #(
   parameter int TimeoutCycles = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int c_CNT_W = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST =
      c_CNT_W'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);

   logic [c_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Fires on the cycle whose increment would make the count equal TimeoutCycles.
   assign o_expired = (TimeoutCycles != 0) && i_en && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/obi_apb_bridge_mc.sv
// ============================================================================
// Module : obi_apb_bridge_mc
// Brief  : OBI subordinate to multi-PSEL APB4 master bridge with address
//          decode, registered responses and ACCESS-phase timeout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module obi_apb_bridge_mc
   import obi_apb_bridge_pkg::*;
#(
   parameter int         AddrWidth     = 32,
   parameter int         DataWidth     = 32,
   parameter int         NumApb        = 4,
   parameter int         SelLsb        = 12,
   parameter int         TimeoutCycles = 255,
   parameter logic [2:0] Pprot         = c_PPROT_DEFAULT
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        obi_req_i,
   output logic                        obi_gnt_o,
   input  logic [AddrWidth-1:0]        obi_addr_i,
   input  logic                        obi_we_i,
   input  logic [DataWidth/8-1:0]      obi_be_i,
   input  logic [DataWidth-1:0]        obi_wdata_i,
   output logic                        obi_rvalid_o,
   output logic [DataWidth-1:0]        obi_rdata_o,
   output logic                        obi_err_o,
   output logic [AddrWidth-1:0]        apb_paddr_o,
   output logic [NumApb-1:0]           apb_psel_o,
   output logic                        apb_penable_o,
   output logic                        apb_pwrite_o,
   output logic [DataWidth-1:0]        apb_pwdata_o,
   output logic [DataWidth/8-1:0]      apb_pstrb_o,
   output logic [2:0]                  apb_pprot_o,
   input  logic [NumApb*DataWidth-1:0] apb_prdata_i,
   input  logic [NumApb-1:0]           apb_pready_i,
   input  logic [NumApb-1:0]           apb_pslverr_i
);

   localparam int c_IDX_W = idx_width(NumApb);
   localparam int c_BE_W  = DataWidth / 8;
   localparam logic [c_IDX_W:0] c_NUM_APB = (c_IDX_W + 1)'(NumApb);

   state_e               r_state;
   state_e               w_state_nxt;
   logic [AddrWidth-1:0] r_addr;
   logic                 r_we;
   logic [c_BE_W-1:0]    r_be;
   logic [DataWidth-1:0] r_wdata;
   logic [c_IDX_W-1:0]   r_idx;
   logic [DataWidth-1:0] r_rdata;
   logic                 r_err;

   logic                 w_gnt;
   logic [c_IDX_W-1:0]   w_dec_idx;
   logic                 w_dec_ok;
   logic                 w_pready_sel;
   logic                 w_slverr_sel;
   logic [DataWidth-1:0] w_prdata_sel;
   logic                 w_expired;
   logic [NumApb-1:0]    w_psel;

   assign w_gnt     = obi_req_i && (r_state == IDLE || r_state == RESP) && !rst_i;
   assign w_dec_idx = obi_addr_i[SelLsb +: c_IDX_W];
   assign w_dec_ok  = ({1'b0, w_dec_idx} < c_NUM_APB);

   // Only the latched subordinate's response lines are observed.
   always_comb begin
      w_pready_sel = 1'b0;
      w_slverr_sel = 1'b0;
      w_prdata_sel = '0;
      for (int i = 0; i < NumApb; i++) begin
         if (r_idx == c_IDX_W'(i)) begin
            w_pready_sel = apb_pready_i[i];
            w_slverr_sel = apb_pslverr_i[i];
            w_prdata_sel = apb_prdata_i[i*DataWidth +: DataWidth];
         end
      end
   end

   always_comb begin
      w_psel = '0;
      if (r_state == SETUP || r_state == ACCESS) begin
         for (int i = 0; i < NumApb; i++) begin
            w_psel[i] = (r_idx == c_IDX_W'(i));
         end
      end
   end

   obi_apb_timeout_cnt #(
      .TimeoutCycles (TimeoutCycles)
   ) u_timeout (
      .clk       (clk_i),
      .rst       (rst_i),
      .i_clr     (r_state == SETUP),
      .i_en      ((r_state == ACCESS) && !w_pready_sel),
      .o_expired (w_expired)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE, RESP: begin
            if (w_gnt) begin
               w_state_nxt = w_dec_ok ? SETUP : RESP;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SETUP:   w_state_nxt = ACCESS;
         ACCESS: begin
            if (w_pready_sel || w_expired) begin
               w_state_nxt = RESP;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_be    <= '0;
         r_wdata <= '0;
         r_idx   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_gnt) begin
            r_addr  <= obi_addr_i;
            r_we    <= obi_we_i;
            r_be    <= obi_be_i;
            r_wdata <= obi_wdata_i;
            r_idx   <= w_dec_idx;
            if (!w_dec_ok) begin
               r_rdata <= '0;
               r_err   <= 1'b1;
            end
         end
         // pready takes priority over a simultaneous timeout.
         if (r_state == ACCESS) begin
            if (w_pready_sel) begin
               r_rdata <= r_we ? '0 : w_prdata_sel;
               r_err   <= w_slverr_sel;
            end else if (w_expired) begin
               r_rdata <= '0;
               r_err   <= 1'b1;
            end
         end
      end
   end

   assign obi_gnt_o     = w_gnt;
   assign obi_rvalid_o  = (r_state == RESP);
   assign obi_rdata_o   = r_rdata;
   assign obi_err_o     = r_err;
   assign apb_paddr_o   = r_addr;
   assign apb_psel_o    = w_psel;
   assign apb_penable_o = (r_state == ACCESS);
   assign apb_pwrite_o  = r_we;
   assign apb_pwdata_o  = r_wdata;
   assign apb_pstrb_o   = r_we ? r_be : '0;
   assign apb_pprot_o   = Pprot;

endmodule

`default_nettype wire

// File: tb/tb_obi_apb_bridge_mc.sv
// ============================================================================
// Module : tb_obi_apb_bridge_mc
// Brief  : Directed self-checking bench for obi_apb_bridge_mc.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_obi_apb_bridge_mc;

   logic         clk = 1'b0;
   logic         rst;
   int           checks = 0;
   int           errors = 0;

   // Four-subordinate bridge with an 8-cycle timeout
   logic         req, we, gnt, rvalid, err, penable, pwrite;
   logic [31:0]  addr, wdata, rdata, paddr, pwdata;
   logic [3:0]   be, pstrb, psel, pready, pslverr;
   logic [2:0]   pprot;
   logic [127:0] prdata;

   // Three-subordinate bridge for the decode-error case
   logic         req3, we3, gnt3, rvalid3, err3, penable3, pwrite3;
   logic [31:0]  addr3, rdata3, paddr3, pwdata3;
   logic [3:0]   pstrb3;
   logic [2:0]   psel3, pprot3;
   logic [95:0]  prdata3;

   always #5 clk = ~clk;

   obi_apb_bridge_mc #(
      .NumApb        (4),
      .TimeoutCycles (8)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .obi_req_i     (req),
      .obi_gnt_o     (gnt),
      .obi_addr_i    (addr),
      .obi_we_i      (we),
      .obi_be_i      (be),
      .obi_wdata_i   (wdata),
      .obi_rvalid_o  (rvalid),
      .obi_rdata_o   (rdata),
      .obi_err_o     (err),
      .apb_paddr_o   (paddr),
      .apb_psel_o    (psel),
      .apb_penable_o (penable),
      .apb_pwrite_o  (pwrite),
      .apb_pwdata_o  (pwdata),
      .apb_pstrb_o   (pstrb),
      .apb_pprot_o   (pprot),
      .apb_prdata_i  (prdata),
      .apb_pready_i  (pready),
      .apb_pslverr_i (pslverr)
   );

   obi_apb_bridge_mc #(
      .NumApb (3)
   ) dut3 (
      .clk_i         (clk),
      .rst_i         (rst),
      .obi_req_i     (req3),
      .obi_gnt_o     (gnt3),
      .obi_addr_i    (addr3),
      .obi_we_i      (we3),
      .obi_be_i      (4'hF),
      .obi_wdata_i   (32'h0),
      .obi_rvalid_o  (rvalid3),
      .obi_rdata_o   (rdata3),
      .obi_err_o     (err3),
      .apb_paddr_o   (paddr3),
      .apb_psel_o    (psel3),
      .apb_penable_o (penable3),
      .apb_pwrite_o  (pwrite3),
      .apb_pwdata_o  (pwdata3),
      .apb_pstrb_o   (pstrb3),
      .apb_pprot_o   (pprot3),
      .apb_prdata_i  (prdata3),
      .apb_pready_i  (3'b111),
      .apb_pslverr_i (3'b000)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req = 1'b1; addr = 32'h0; we = 1'b0; be = 4'h0; wdata = 32'h0;
      pready = 4'h0; pslverr = 4'h0; prdata = '0;
      req3 = 1'b0; addr3 = 32'h0; we3 = 1'b0; prdata3 = {3{32'hFFFF_FFFF}};

      // Reset state
      tick(); tick();
      chk("rst_gnt", {31'b0, gnt}, 32'd0);
      chk("rst_psel", {28'b0, psel}, 32'd0);
      chk("rst_penable", {31'b0, penable}, 32'd0);
      chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_paddr", paddr, 32'h0);
      chk("rst_pprot", {29'b0, pprot}, 32'd2);
      req = 1'b0; rst = 1'b0;
      tick();

      // 1: zero-wait read from subordinate 2
      prdata[2*32 +: 32] = 32'hDEAD_BEEF; pready = 4'b0100;
      req = 1'b1; addr = 32'h0000_2004; we = 1'b0; be = 4'hF;
      #1 chk("t1_gnt", {31'b0, gnt}, 32'd1);
      tick(); req = 1'b0;
      chk("t1_setup_psel", {28'b0, psel}, 32'b0100);
      chk("t1_setup_penable", {31'b0, penable}, 32'd0);
      chk("t1_paddr", paddr, 32'h0000_2004);
      chk("t1_pstrb", {28'b0, pstrb}, 32'd0);
      tick();
      chk("t1_access_psel", {28'b0, psel}, 32'b0100);
      chk("t1_access_penable", {31'b0, penable}, 32'd1);
      chk("t1_access_rvalid", {31'b0, rvalid}, 32'd0);
      tick();
      chk("t1_rvalid", {31'b0, rvalid}, 32'd1);
      chk("t1_rdata", rdata, 32'hDEAD_BEEF);
      chk("t1_err", {31'b0, err}, 32'd0);
      chk("t1_resp_psel", {28'b0, psel}, 32'd0);
      tick();
      chk("t1_rvalid_pulse", {31'b0, rvalid}, 32'd0);
      chk("t1_rdata_hold", rdata, 32'hDEAD_BEEF);

      // 2: write with two wait states, completed with PSLVERR
      pready = 4'h0; pslverr = 4'b1000;
      req = 1'b1; addr = 32'h0000_3010; we = 1'b1; be = 4'b0011; wdata = 32'h1234_5678;
      #1 chk("t2_gnt", {31'b0, gnt}, 32'd1);
      tick(); req = 1'b0; we = 1'b0; be = 4'h0; wdata = 32'h0;
      chk("t2_setup_psel", {28'b0, psel}, 32'b1000);
      chk("t2_pwrite", {31'b0, pwrite}, 32'd1);
      chk("t2_pstrb", {28'b0, pstrb}, 32'b0011);
      chk("t2_setup_pwdata", pwdata, 32'h1234_5678);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t2_access_penable", {31'b0, penable}, 32'd1);
         chk("t2_access_psel", {28'b0, psel}, 32'b1000);
         chk("t2_access_pwdata", pwdata, 32'h1234_5678);
         if (k == 2) pready = 4'b1000;
      end
      tick();
      chk("t2_rvalid", {31'b0, rvalid}, 32'd1);
      chk("t2_err", {31'b0, err}, 32'd1);
      chk("t2_rdata", rdata, 32'h0);
      pready = 4'h0; pslverr = 4'h0;
      tick();

      // 3: decode error on the three-subordinate bridge
      req3 = 1'b1; addr3 = 32'h0000_3000; we3 = 1'b0;
      #1 chk("t3_gnt", {31'b0, gnt3}, 32'd1);
      tick(); req3 = 1'b0;
      chk("t3_rvalid", {31'b0, rvalid3}, 32'd1);
      chk("t3_err", {31'b0, err3}, 32'd1);
      chk("t3_rdata", rdata3, 32'h0);
      chk("t3_psel", {29'b0, psel3}, 32'd0);
      tick();
      chk("t3_psel_after", {29'b0, psel3}, 32'd0);
      chk("t3_rvalid_pulse", {31'b0, rvalid3}, 32'd0);

      // 4a: subordinate 1 never ready -> timeout after 8 ACCESS cycles
      req = 1'b1; addr = 32'h0000_1000; we = 1'b0;
      #1 chk("t4a_gnt", {31'b0, gnt}, 32'd1);
      tick(); req = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("t4a_access_psel", {28'b0, psel}, 32'b0010);
         chk("t4a_access_penable", {31'b0, penable}, 32'd1);
      end
      tick();
      chk("t4a_psel_released", {28'b0, psel}, 32'd0);
      chk("t4a_rvalid", {31'b0, rvalid}, 32'd1);
      chk("t4a_err", {31'b0, err}, 32'd1);
      chk("t4a_rdata", rdata, 32'h0);
      tick();

      // 4b: pready on the 8th ACCESS cycle beats the timeout
      prdata[1*32 +: 32] = 32'hCAFE_0001;
      req = 1'b1; addr = 32'h0000_1000; we = 1'b0;
      #1 chk("t4b_gnt", {31'b0, gnt}, 32'd1);
      tick(); req = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("t4b_access_psel", {28'b0, psel}, 32'b0010);
         if (k == 7) pready = 4'b0010;
      end
      tick();
      chk("t4b_rvalid", {31'b0, rvalid}, 32'd1);
      chk("t4b_err", {31'b0, err}, 32'd0);
      chk("t4b_rdata", rdata, 32'hCAFE_0001);
      pready = 4'h0;
      tick();

      // 5: back-to-back reads to subordinates 0 and 1
      prdata[0*32 +: 32] = 32'h1111_0000; prdata[1*32 +: 32] = 32'h2222_1111;
      pready = 4'b0011;
      req = 1'b1; addr = 32'h0000_0000; we = 1'b0;
      #1 chk("t5_gnt0", {31'b0, gnt}, 32'd1);
      tick(); addr = 32'h0000_1000;
      chk("t5_psel_c1", {28'b0, psel}, 32'b0001);
      chk("t5_gnt_setup", {31'b0, gnt}, 32'd0);
      tick();
      chk("t5_psel_c2", {28'b0, psel}, 32'b0001);
      chk("t5_gnt_access", {31'b0, gnt}, 32'd0);
      tick();
      chk("t5_psel_c3", {28'b0, psel}, 32'b0000);
      chk("t5_rvalid0", {31'b0, rvalid}, 32'd1);
      chk("t5_rdata0", rdata, 32'h1111_0000);
      chk("t5_gnt1", {31'b0, gnt}, 32'd1);
      tick(); req = 1'b0;
      chk("t5_psel_c4", {28'b0, psel}, 32'b0010);
      chk("t5_rvalid_gap", {31'b0, rvalid}, 32'd0);
      tick();
      chk("t5_psel_c5", {28'b0, psel}, 32'b0010);
      tick();
      chk("t5_rvalid1", {31'b0, rvalid}, 32'd1);
      chk("t5_rdata1", rdata, 32'h2222_1111);
      chk("t5_err1", {31'b0, err}, 32'd0);
      pready = 4'h0;
      tick();

      // 6: reset during ACCESS, then a fresh transfer
      req = 1'b1; addr = 32'h0000_0000; we = 1'b0;
      tick(); req = 1'b0;
      tick();
      chk("t6_in_access", {31'b0, penable}, 32'd1);
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk("t6_psel", {28'b0, psel}, 32'd0);
      chk("t6_penable", {31'b0, penable}, 32'd0);
      chk("t6_rvalid", {31'b0, rvalid}, 32'd0);
      chk("t6_gnt", {31'b0, gnt}, 32'd0);
      tick();
      chk("t6_no_late_rvalid", {31'b0, rvalid}, 32'd0);
      prdata[2*32 +: 32] = 32'h5A5A_5A5A; pready = 4'b0100;
      req = 1'b1; addr = 32'h0000_2000; we = 1'b0;
      #1 chk("t6_new_gnt", {31'b0, gnt}, 32'd1);
      tick(); req = 1'b0;
      chk("t6_new_psel", {28'b0, psel}, 32'b0100);
      tick(); tick();
      chk("t6_new_rvalid", {31'b0, rvalid}, 32'd1);
      chk("t6_new_rdata", rdata, 32'h5A5A_5A5A);
      chk("t6_new_err", {31'b0, err}, 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
